// File: rtl/top2_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : top2_rr_scheduler_if
//  Description : Sample-in / result-out bundle for the shared top-two
//                scheduler. Producers and the consumer sit on the master
//                side; the scheduler itself uses the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface top2_rr_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) ();

    // Per-channel sample side
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH-1:0]            ch_clr;

    // Shared result side
    logic                         out_valid;
    logic                         out_ready;
    logic [CH_W-1:0]              out_ch;
    logic [DATA_WIDTH-1:0]        out_largest;
    logic [DATA_WIDTH-1:0]        out_second;

    // Producers and consumer
    modport master (
        output in_valid,
        output in_data,
        output ch_clr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ch,
        input  out_largest,
        input  out_second
    );

    // Scheduler
    modport slave (
        input  in_valid,
        input  in_data,
        input  ch_clr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ch,
        output out_largest,
        output out_second
    );

endinterface
`default_nettype wire

// File: rtl/top2_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : top2_rr_scheduler
//  Description : Round-robin scheduler sharing one top-two (largest /
//                second-largest) update datapath between NUM_CH sample
//                streams. Per-channel context lives in register banks; each
//                accepted sample produces a registered result with
//                backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module top2_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    top2_rr_scheduler_if.slave    bus
);

    localparam logic [CH_W:0]   c_num_ch  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CH_W-1:0]       r_ptr;
    logic [DATA_WIDTH-1:0] r_largest [NUM_CH];
    logic [DATA_WIDTH-1:0] r_second  [NUM_CH];

    logic                  r_out_valid;
    logic [CH_W-1:0]       r_out_ch;
    logic [DATA_WIDTH-1:0] r_out_largest;
    logic [DATA_WIDTH-1:0] r_out_second;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  w_slot_free;
    logic                  w_gnt_any;
    logic [CH_W-1:0]       w_gnt_idx;
    logic [CH_W:0]         w_scan_idx;
    logic                  w_accept;
    logic [NUM_CH-1:0]     w_in_ready;
    logic [DATA_WIDTH-1:0] w_samples [NUM_CH];
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_gnt_clr;
    logic [DATA_WIDTH-1:0] w_old_l;
    logic [DATA_WIDTH-1:0] w_old_s;
    logic [DATA_WIDTH-1:0] w_new_l;
    logic [DATA_WIDTH-1:0] w_new_s;

    // Split the flat sample bus into one word per channel
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_samples[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // The output slot can take a new result if it is empty or being drained
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Round-robin search: scan from the pointer upward with wrap. The scan
    // runs from the farthest candidate back to the pointer so the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, r_ptr} + (CH_W+1)'(k);
            if (w_scan_idx >= c_num_ch) begin
                w_scan_idx = w_scan_idx - c_num_ch;
            end
            if (bus.in_valid[w_scan_idx[CH_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx[CH_W-1:0];
            end
        end
    end

    // The grant only reaches in_ready when the result slot can accept it;
    // a granted channel always has in_valid set, so a grant is an accept.
    assign w_accept   = w_gnt_any && w_slot_free;
    assign w_in_ready = w_accept ? (NUM_CH'(1) << w_gnt_idx) : '0;

    // Top-two update for the granted channel. A same-edge clear wipes the
    // old context first so the sample opens a fresh sequence.
    always_comb begin
        w_data    = w_samples[w_gnt_idx];
        w_gnt_clr = bus.ch_clr[w_gnt_idx];
        w_old_l   = w_gnt_clr ? '0 : r_largest[w_gnt_idx];
        w_old_s   = w_gnt_clr ? '0 : r_second[w_gnt_idx];
        w_new_l   = w_old_l;
        w_new_s   = w_old_s;
        if (w_data >= w_old_l) begin
            // Ties displace the old largest: equal values are separate entries
            w_new_l = w_data;
            w_new_s = w_old_l;
        end else if (w_data >= w_old_s) begin
            w_new_s = w_data;
        end
    end

    // Round-robin pointer: moves just past the channel that was accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == c_last_ch) ? '0 : (w_gnt_idx + CH_W'(1));
        end
    end

    // Per-channel context banks: accepted channel takes the update, any
    // other channel with its clear bit set returns to an empty sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_largest[i] <= '0;
                r_second[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept && (w_gnt_idx == CH_W'(i))) begin
                    r_largest[i] <= w_new_l;
                    r_second[i]  <= w_new_s;
                end else if (bus.ch_clr[i]) begin
                    r_largest[i] <= '0;
                    r_second[i]  <= '0;
                end
            end
        end
    end

    // Result register: loads on accept, holds under backpressure, empties
    // when drained without a replacement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_ch      <= '0;
            r_out_largest <= '0;
            r_out_second  <= '0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_ch      <= w_gnt_idx;
            r_out_largest <= w_new_l;
            r_out_second  <= w_new_s;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_ch      = r_out_ch;
    assign bus.out_largest = r_out_largest;
    assign bus.out_second  = r_out_second;

endmodule
`default_nettype wire

// File: tb/tb_top2_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top2_rr_scheduler
//  Description : Directed self-checking bench for top2_rr_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top2_rr_scheduler;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    top2_rr_scheduler_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CHW)) bus ();

    top2_rr_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Advance to just after the next active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.ch_clr    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] v);
        bus.in_data[ch*DW +: DW] = v;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid);
        end
        n_tests++;
        if ({bus.out_ch, bus.out_largest, bus.out_second} !== '0) begin
            n_fail++; $display("FAIL reset_out_fields got ch=%0d L=%0d S=%0d exp 0/0/0",
                               bus.out_ch, bus.out_largest, bus.out_second);
        end
        reset = 1'b0;
        bus.in_valid = 4'b1001;
        #1;
        n_tests++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ptr_zero got %b exp 0001", bus.in_ready);
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_stream();
        int d  [5] = '{2, 6, 0, 14, 12};
        int eL [5] = '{2, 6, 6, 14, 14};
        int eS [5] = '{0, 2, 2, 6, 12};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 4'b0001;
            set_data(0, DW'(d[k]));
            #1;
            if (k == 0) begin
                n_tests++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL single_latency got valid=%0b exp 0 before edge", bus.out_valid);
                end
            end
            n_tests++;
            if (bus.in_ready !== 4'b0001) begin
                n_fail++; $display("FAIL single_ready[%0d] got %b exp 0001", k, bus.in_ready);
            end
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
                {1'b1, 2'd0, DW'(eL[k]), DW'(eS[k])}) begin
                n_fail++; $display("FAIL single_result[%0d] got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=0 L=%0d S=%0d",
                                   k, bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second, eL[k], eS[k]);
            end
        end
        idle_inputs();
        step();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain got valid=%0b exp 0", bus.out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_duplicate();
        int d  [3] = '{5, 5, 3};
        int eS [3] = '{0, 5, 5};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 4'b0010;
            set_data(1, DW'(d[k]));
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
                {1'b1, 2'd1, DW'(5), DW'(eS[k])}) begin
                n_fail++; $display("FAIL dup_result[%0d] got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=1 L=5 S=%0d",
                                   k, bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second, eS[k]);
            end
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_rotation();
        int m  [10] = '{15, 15, 15, 15, 15, 15, 11, 11, 11, 11};
        int v  [10] = '{10, 20, 30, 40,  5, 15, 41, 12, 25,  2};
        int eg [10] = '{ 0,  1,  2,  3,  0,  1,  3,  0,  1,  3};
        int eL [10] = '{10, 20, 30, 40, 10, 20, 41, 12, 25, 41};
        int eS [10] = '{ 0,  0,  0,  0,  5, 15, 40, 10, 20, 40};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = NCH'(m[k]);
            for (int c = 0; c < NCH; c++) set_data(c, DW'(v[k]));
            #1;
            n_tests++;
            if (bus.in_ready !== NCH'(1 << eg[k])) begin
                n_fail++; $display("FAIL rot_grant[%0d] got %b exp ch%0d", k, bus.in_ready, eg[k]);
            end
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
                {1'b1, CHW'(eg[k]), DW'(eL[k]), DW'(eS[k])}) begin
                n_fail++; $display("FAIL rot_result[%0d] got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=%0d L=%0d S=%0d",
                                   k, bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second, eg[k], eL[k], eS[k]);
            end
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        do_reset();
        bus.in_valid = 4'b0001;
        set_data(0, DW'(8));
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0011;
        set_data(0, DW'(20));
        set_data(1, DW'(3));
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready_low[%0d] got %b exp 0000", k, bus.in_ready);
            end
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
                {1'b1, 2'd0, DW'(8), DW'(0)}) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=0 L=8 S=0",
                                   k, bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release_grant got %b exp 0010", bus.in_ready);
        end
        step();
        n_tests++;
        if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
            {1'b1, 2'd1, DW'(3), DW'(0)}) begin
            n_fail++; $display("FAIL bp_release_result got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=1 L=3 S=0",
                               bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second);
        end
        bus.in_valid = 4'b0001;
        set_data(0, DW'(6));
        step();
        n_tests++;
        if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
            {1'b1, 2'd0, DW'(8), DW'(6)}) begin
            n_fail++; $display("FAIL bp_no_ctx_change got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=0 L=8 S=6",
                               bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second);
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_clear();
        int ch [6] = '{0, 0, 1, 0, 0, 1};
        int d  [6] = '{9, 4, 50, 7, 3, 1};
        int cl [6] = '{0, 0, 0, 3, 0, 0};
        int eL [6] = '{9, 9, 50, 7, 7, 1};
        int eS [6] = '{0, 4, 0, 0, 3, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = NCH'(1 << ch[k]);
            bus.ch_clr   = NCH'(cl[k]);
            set_data(ch[k], DW'(d[k]));
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
                {1'b1, CHW'(ch[k]), DW'(eL[k]), DW'(eS[k])}) begin
                n_fail++; $display("FAIL clr_result[%0d] got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=%0d L=%0d S=%0d",
                                   k, bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second, ch[k], eL[k], eS[k]);
            end
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        do_reset();
        bus.in_valid = 4'b0001;
        set_data(0, DW'(5));
        step();
        n_tests++;
        if ({bus.out_valid, bus.out_largest} !== {1'b1, DW'(5)}) begin
            n_fail++; $display("FAIL arst_setup got v=%0b L=%0d exp v=1 L=5", bus.out_valid, bus.out_largest);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL arst_valid_drop got %0b exp 0", bus.out_valid);
        end
        n_tests++;
        if ({bus.out_ch, bus.out_largest, bus.out_second} !== '0) begin
            n_fail++; $display("FAIL arst_out_zero got ch=%0d L=%0d S=%0d exp 0/0/0",
                               bus.out_ch, bus.out_largest, bus.out_second);
        end
        #2;
        reset = 1'b0;
        bus.in_valid = 4'b0011;
        set_data(0, DW'(1));
        set_data(1, DW'(1));
        #1;
        n_tests++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL arst_ptr got %b exp 0001", bus.in_ready);
        end
        step();
        n_tests++;
        if ({bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second} !==
            {1'b1, 2'd0, DW'(1), DW'(0)}) begin
            n_fail++; $display("FAIL arst_first_sample got v=%0b ch=%0d L=%0d S=%0d exp v=1 ch=0 L=1 S=0",
                               bus.out_valid, bus.out_ch, bus.out_largest, bus.out_second);
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_stream();
        test_duplicate();
        test_rotation();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top2_rr_scheduler.md
Name: top2_rr_scheduler

Overview:
- Shares a single top-two (largest / second-largest) update datapath between NUM_CH independent sample streams.
- Arbitrates round-robin among requesting channels and accepts at most one sample per cycle.
- Holds per-channel context (largest, second) in register banks and presents each channel's updated second-largest on a registered result stream with backpressure.
- Sits between per-source sample producers and downstream statistics consumers.

Parameters:
- DATA_WIDTH, 32, width of samples and results (unsigned).
- NUM_CH, 4, number of requesting channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel sample valid.
- in_data  input  NUM_CH*DATA_WIDTH  per-channel sample; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_CH  one-hot grant; sample i is accepted when in_valid[i] && in_ready[i].
- ch_clr  input  NUM_CH  per-channel sequence restart, sampled on each rising edge.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_ch  output  CH_W  channel of the result.
- out_largest  output  DATA_WIDTH  that channel's largest value after the update.
- out_second  output  DATA_WIDTH  that channel's second-largest value after the update.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_ch=0, out_largest=0, out_second=0.
  - All per-channel largest/second = 0.
  - RR pointer = 0 (channel 0 has highest priority).
- slot_free = !out_valid || out_ready.
- in_ready:
  - All zero when !slot_free.
  - Otherwise one-hot on the first channel with in_valid set, searching from the RR pointer upward with wrap.
  - in_ready is combinational from in_valid, pointer and out_valid/out_ready.
  - in_ready[i] never asserts without in_valid[i].
- RR pointer: after an accept on channel g, pointer = (g+1) mod NUM_CH. It is unchanged on cycles with no accept.
- Update rule for accepted sample d on channel g, using old values L and S:
  - If d >= L: S <= L, L <= d. Equal values count as new entries.
  - Else if d >= S: S <= d.
  - Else: no change.
  - Unsigned compares; no arithmetic and no overflow.
- Result latency:
  - The result register loads on the accept edge: out_valid=1, out_ch=g, out_largest/out_second = the new L/S.
  - The result is visible one cycle after the accept.
- Result hold and release:
  - The result is held stable while out_valid && !out_ready.
  - If there is no accept in a cycle with out_ready=1, out_valid falls to 0.
  - Back-to-back accepts are allowed every cycle while out_ready=1, giving full throughput.
- Early sequence: the first sample of a sequence gives out_second=0. A sequence with fewer than two samples reports 0.
- ch_clr[i]:
  - Sets channel i's L and S to 0 at the edge.
  - If channel i is also accepted on the same edge, the clear applies first and the sample starts the new sequence: L=d, S=0, and that result is emitted.
  - ch_clr does not affect a result already in the output register, nor the RR pointer.
- Multiple channels may clear simultaneously.
- No combinational path from in_data to outputs.
- Reset mid-operation: all state returns to reset values immediately. Any pending result and in-flight sample are discarded.

Test Plan:
- Single channel 0 stream 2,6,0,14,12 with out_ready=1 -> out_second sequence 0,2,2,6,12; out_largest 2,6,6,14,14; each result one cycle after its accept.
- Duplicate maxima on channel 1: stream 5,5,3 -> out_second 0,5,5.
- Channels 0..3 all valid continuously with distinct data -> grants rotate 0,1,2,3,0; each channel keeps independent L/S. Then drop ch2 valid -> rotation 3,0,1,3, with ch2 skipped.
- Backpressure: out_ready=0 for 3 cycles while a result is pending -> in_ready all 0, result stable, no context change; on out_ready=1 the next accept occurs in that same cycle.
- ch_clr[0] with a simultaneous accept of 7 on ch0, after a prior 9,4 -> result L=7, S=0; a subsequent sample 3 -> S=3.
- Assert reset asynchronously mid-stream with out_valid=1 -> out_valid=0 before the next edge, all contexts 0, pointer 0; the first post-reset sample 1 on ch0 gives out_second=0.
